// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Each transaction walks IDLE -> EXEC -> RESP with registered operands and result.
module alu_share_arbiter #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    output logic [NUM_REQ-1:0]       REQ_READY,
    input  logic [3*NUM_REQ-1:0]     REQ_OP,
    input  logic [WIDTH*NUM_REQ-1:0] REQ_A,
    input  logic [WIDTH*NUM_REQ-1:0] REQ_B,
    output logic [2:0]               ALU_OP,
    output logic [WIDTH-1:0]         ALU_A,
    output logic [WIDTH-1:0]         ALU_B,
    input  logic [WIDTH-1:0]         ALU_RESULT,
    output logic [NUM_REQ-1:0]       RSP_VALID,
    input  logic [NUM_REQ-1:0]       RSP_READY,
    output logic [WIDTH-1:0]         RSP_DATA,
    output logic                     RSP_ERR,
    output logic [IDW-1:0]           GRANT_ID,
    output logic                     BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    state_t               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_d;
    logic [IDW-1:0]       grant_q;
    logic [2:0]           alu_op_q;
    logic [WIDTH-1:0]     alu_a_q;
    logic [WIDTH-1:0]     alu_b_q;
    logic [WIDTH-1:0]     rsp_data_q;
    logic                 rsp_err_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 busy_q;

    logic                 win_vld;
    logic [IDW-1:0]       win_id;
    logic [IDW:0]         cand_sum;
    logic [IDW-1:0]       cand;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Scan upward from the pointer, wrapping modulo NUM_REQ (not a power of two in general).
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
            end
            cand = cand_sum[IDW-1:0];
            if (!win_vld && REQ_VALID[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        if (win_id == IDW'(NUM_REQ-1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_id + 1'b1;
        end
    end

    // Accept is gated by reset so nothing handshakes while the block is held in reset.
    assign REQ_READY = (RESET_N && (state_q == ST_IDLE) && win_vld) ? onehot(win_id) : '0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        alu_op_q <= REQ_OP[3*win_id +: 3];
                        alu_a_q  <= REQ_A[WIDTH*win_id +: WIDTH];
                        alu_b_q  <= REQ_B[WIDTH*win_id +: WIDTH];
                        grant_q  <= win_id;
                        ptr_q    <= ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= (alu_op_q == OP_ILLEGAL) ? '0 : ALU_RESULT;
                    rsp_err_q   <= (alu_op_q == OP_ILLEGAL);
                    rsp_valid_q <= onehot(grant_q);
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's ready completes the response.
                    if (RSP_READY[grant_q]) begin
                        rsp_valid_q <= '0;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ALU_OP    = alu_op_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign GRANT_ID  = grant_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on ALU_OP/A/B.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [1:0]  grant_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_share_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_OP     (req_op),
        .REQ_A      (req_a),
        .REQ_B      (req_b),
        .ALU_OP     (alu_op),
        .ALU_A      (alu_a),
        .ALU_B      (alu_b),
        .ALU_RESULT (alu_result),
        .RSP_VALID  (rsp_valid),
        .RSP_READY  (rsp_ready),
        .RSP_DATA   (rsp_data),
        .RSP_ERR    (rsp_err),
        .GRANT_ID   (grant_id),
        .BUSY       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; op 7 returns junk so the forced-zero response is visible.
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a >> alu_b[2:0];
            3'd3:    alu_result = 8'($signed(alu_a) >>> alu_b[2:0]);
            3'd4:    alu_result = alu_a << alu_b[2:0];
            3'd5:    alu_result = alu_a & alu_b;
            3'd6:    alu_result = alu_a | alu_b;
            default: alu_result = 8'hA5;
        endcase
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if ({rsp_valid, busy, alu_op, alu_a, alu_b, rsp_data, rsp_err, grant_id} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs got rsp_valid=%b busy=%b op=%0d a=%h b=%h data=%h err=%b gid=%0d exp all 0",
                     rsp_valid, busy, alu_op, alu_a, alu_b, rsp_data, rsp_err, grant_id);
        end
        step();
        step();
        req_valid = 4'h0;
        rst_n     = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_idle got busy=%b ready=%b exp 0/0000", busy, req_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_sub [4];
        logic [3:0] exp_rdy;
        int id;
        exp_sub[0] = 8'h0F; exp_sub[1] = 8'h1E; exp_sub[2] = 8'h2D; exp_sub[3] = 8'h3C;
        req_op    = {3'd1, 3'd1, 3'd1, 3'd1};
        req_a     = {8'h40, 8'h30, 8'h20, 8'h10};
        req_b     = {8'h04, 8'h03, 8'h02, 8'h01};
        rsp_ready = 4'hF;
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            id = g % 4;
            exp_rdy = 4'b0001 << id;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rr_grant%0d ready got=%b exp=%b", g, req_ready, exp_rdy);
            end
            step();
            if (g == 4) req_valid = 4'h0;
            checks++;
            if (grant_id !== 2'(id) || busy !== 1'b1 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_exec%0d got gid=%0d busy=%b ready=%b exp gid=%0d busy=1 ready=0000",
                                   g, grant_id, busy, req_ready, id);
            end
            step();
            checks++;
            if (rsp_valid !== exp_rdy || rsp_data !== exp_sub[id] || req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_resp%0d got valid=%b data=%h ready=%b exp valid=%b data=%h ready=0000",
                                   g, rsp_valid, rsp_data, req_ready, exp_rdy, exp_sub[id]);
            end
            step();
        end
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL rr_end got valid=%b busy=%b exp 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_single();
        req_op    = 12'd0;
        req_a     = {8'h00, 8'h00, 8'h05, 8'h00};
        req_b     = {8'h00, 8'h00, 8'h03, 8'h00};
        rsp_ready = 4'hF;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL single_ready got=%b exp=0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        checks++;
        if (alu_op !== 3'd0 || alu_a !== 8'h05 || alu_b !== 8'h03 || grant_id !== 2'd1 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL single_exec got op=%0d a=%h b=%h gid=%0d valid=%b exp 0/05/03/1/0000",
                               alu_op, alu_a, alu_b, grant_id, rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 8'h08 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_resp got valid=%b data=%h err=%b exp 0010/08/0", rsp_valid, rsp_data, rsp_err);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || alu_a !== 8'h05) begin
            errors++; $display("FAIL single_done got valid=%b busy=%b alu_a=%h exp 0000/0/05", rsp_valid, busy, alu_a);
        end
    endtask

    task automatic test_backpressure();
        req_op    = {3'd0, 3'd4, 3'd0, 3'd0};
        req_a     = {8'h00, 8'h81, 8'h00, 8'h00};
        req_b     = {8'h00, 8'h01, 8'h00, 8'h00};
        rsp_ready = 4'b0000;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_ready got=%b exp=0100", req_ready);
        end
        step();
        req_valid = 4'b0001;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 4'b0100 || rsp_data !== 8'h02 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d got valid=%b data=%h ready=%b busy=%b exp 0100/02/0000/1",
                                   c, rsp_valid, rsp_data, req_ready, busy);
            end
            step();
        end
        rsp_ready = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_release_ready got=%b exp=0000", req_ready);
        end
        step();
        req_valid = 4'b0000;
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_done got valid=%b busy=%b exp 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_illegal();
        req_op    = {3'd7, 3'd0, 3'd0, 3'd0};
        req_a     = {8'hFF, 8'h00, 8'h00, 8'h00};
        req_b     = {8'hFF, 8'h00, 8'h00, 8'h00};
        rsp_ready = 4'hF;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL illegal_ready got=%b exp=1000", req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 8'h00 || rsp_err !== 1'b1 || grant_id !== 2'd3) begin
            errors++; $display("FAIL illegal_resp got valid=%b data=%h err=%b gid=%0d exp 1000/00/1/3",
                               rsp_valid, rsp_data, rsp_err, grant_id);
        end
        step();
        checks++;
        if (rsp_err !== 1'b0 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL illegal_clear got err=%b valid=%b exp 0/0000", rsp_err, rsp_valid);
        end
    endtask

    task automatic test_wrong_owner();
        req_op    = {3'd0, 3'd0, 3'd5, 3'd0};
        req_a     = {8'h00, 8'h00, 8'h3C, 8'h00};
        req_b     = {8'h00, 8'h00, 8'h0F, 8'h00};
        rsp_ready = 4'b0100;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL owner_ready got=%b exp=0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_data !== 8'h0C || busy !== 1'b1) begin
                errors++; $display("FAIL owner_hold%0d got valid=%b data=%h busy=%b exp 0010/0C/1",
                                   c, rsp_valid, rsp_data, busy);
            end
            step();
        end
        rsp_ready = 4'b0010;
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL owner_done got valid=%b busy=%b exp 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        req_op    = 12'd0;
        req_a     = {8'h00, 8'h01, 8'h00, 8'h00};
        req_b     = {8'h00, 8'h01, 8'h00, 8'h00};
        rsp_ready = 4'hF;
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        checks++;
        if (busy !== 1'b1 || alu_a !== 8'h01) begin
            errors++; $display("FAIL midrst_exec got busy=%b alu_a=%h exp 1/01", busy, alu_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, alu_op, alu_a, alu_b, rsp_data, rsp_err, grant_id, req_ready} !== 40'd0) begin
            errors++; $display("FAIL midrst_outputs got valid=%b busy=%b a=%h b=%h gid=%0d ready=%b exp all 0",
                               rsp_valid, busy, alu_a, alu_b, grant_id, req_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_dropped got valid=%b busy=%b exp 0000/0", rsp_valid, busy);
        end
        req_op    = 12'd0;
        req_a     = {8'h09, 8'h00, 8'h00, 8'h07};
        req_b     = {8'h09, 8'h00, 8'h00, 8'h02};
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_priority got=%b exp=0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        checks++;
        if (grant_id !== 2'd0) begin
            errors++; $display("FAIL midrst_gid got=%0d exp=0", grant_id);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 8'h09) begin
            errors++; $display("FAIL midrst_resp got valid=%b data=%h exp 0001/09", rsp_valid, rsp_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_illegal();
        test_wrong_owner();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
